// File: rtl/post_cov_semipar_pkg.sv
// post_cov_semipar_pkg: shared fixed-point format defaults and FSM state encoding.
// Build option: define POST_COV_SYMM_EN to symmetrise the off-diagonal outputs.
package post_cov_semipar_pkg;
    localparam int FXP_N    = 16;
    localparam int FXP_FRAC = 8;
    // M0..R3 are consecutive so the low two bits minus one give the matrix entry index
    typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, R0, R1, R2, R3, DONE} state_t;
endpackage

// File: rtl/post_cov_semipar_fxp_dot2.sv
// fxp_dot2: saturating fixed-point two-term dot product (a0*b0 + a1*b1) >>> FRAC.
module fxp_dot2 #(
    parameter int N    = 16,
    parameter int FRAC = 8
) (
    input  logic signed [N-1:0] a0,
    input  logic signed [N-1:0] b0,
    input  logic signed [N-1:0] a1,
    input  logic signed [N-1:0] b1,
    output logic signed [N-1:0] y,
    output logic                ovf
);
    localparam logic signed [N-1:0] MAX_N = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};
    logic signed [2*N-1:0] p0, p1;
    logic signed [2*N:0]   sum, sh;
    logic                  hi, lo;
    always_comb begin
        p0  = a0 * b0;
        p1  = a1 * b1;
        sum = (2*N+1)'(p0) + (2*N+1)'(p1);
        sh  = sum >>> FRAC;
        hi  = sh > (2*N+1)'(MAX_N);
        lo  = sh < (2*N+1)'(MIN_N);
        y   = hi ? MAX_N : lo ? MIN_N : sh[N-1:0];
        ovf = hi | lo;
    end
endmodule

// File: rtl/post_cov_semipar.sv
// post_cov_semipar: P_post = (I - K*H) * P_prior on one shared dot-product unit, 8-cycle job.
// Build option: POST_COV_SYMM_EN averages P01/P10 into a symmetric result.
module post_cov_semipar
    import post_cov_semipar_pkg::*;
#(
    parameter int N    = FXP_N,
    parameter int FRAC = FXP_FRAC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [N-1:0] k00, k01, k10, k11,
    input  logic signed [N-1:0] h00, h01, h10, h11,
    input  logic signed [N-1:0] p00, p01, p10, p11,
    output logic                done,
    output logic                ovf,
    output logic signed [N-1:0] P_POST00, P_POST01, P_POST10, P_POST11
);
    localparam logic signed [N:0] S    = (N+1)'(2**FRAC);
    localparam logic signed [N:0] MAXW = (N+1)'(2**(N-1) - 1);
    localparam logic signed [N:0] MINW = -(N+1)'(2**(N-1));
    state_t state, nxt;
    logic signed [N-1:0] k[4], h[4], p[4], m[4];
    logic signed [N-1:0] r00, r01, r10;
    logic signed [N-1:0] a0, b0, a1, b1, y, msat, o01, o10;
    logic signed [N:0]   diff;
    logic [1:0] ij;
    logic acc, is_m, is_r, dov, mov;
    assign acc  = start && (state == IDLE || state == DONE);
    assign is_m = state inside {M0, M1, M2, M3};
    assign is_r = state inside {R0, R1, R2, R3};
    assign ij   = state[1:0] - 2'd1;
    always_comb begin
        a0 = is_m ? k[{ij[1], 1'b0}] : m[{ij[1], 1'b0}];
        a1 = is_m ? k[{ij[1], 1'b1}] : m[{ij[1], 1'b1}];
        b0 = is_m ? h[{1'b0, ij[0]}] : p[{1'b0, ij[0]}];
        b1 = is_m ? h[{1'b1, ij[0]}] : p[{1'b1, ij[0]}];
    end
    fxp_dot2 #(.N(N), .FRAC(FRAC)) u_dot (
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .y(y), .ovf(dov)
    );
    always_comb begin
        diff = (ij[1] == ij[0] ? S : '0) - (N+1)'(y);
        mov  = diff > MAXW || diff < MINW;
        msat = diff > MAXW ? MAXW[N-1:0] : diff < MINW ? MINW[N-1:0] : diff[N-1:0];
    end
`ifdef POST_COV_SYMM_EN
    logic signed [N:0] avg;
    always_comb begin
        avg = ((N+1)'(r01) + (N+1)'(r10)) >>> 1;
        o01 = avg[N-1:0];
        o10 = avg[N-1:0];
    end
`else
    always_comb begin
        o01 = r01;
        o10 = r10;
    end
`endif
    always_comb begin
        nxt = state;
        if (acc) nxt = M0;
        else if (state != IDLE && state != DONE) nxt = state == R3 ? DONE : state_t'(state + 4'd1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
            ovf   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                k[i] <= '0;
                h[i] <= '0;
                p[i] <= '0;
                m[i] <= '0;
            end
            {r00, r01, r10} <= '0;
            {P_POST00, P_POST01, P_POST10, P_POST11} <= '0;
        end else begin
            state <= nxt;
            if (acc) begin
                k[0] <= k00; k[1] <= k01; k[2] <= k10; k[3] <= k11;
                h[0] <= h00; h[1] <= h01; h[2] <= h10; h[3] <= h11;
                p[0] <= p00; p[1] <= p01; p[2] <= p10; p[3] <= p11;
                done <= 1'b0;
                ovf  <= 1'b0;
            end
            if (is_m) begin
                m[ij] <= msat;
                ovf   <= ovf | dov | mov;
            end
            if (is_r) ovf <= ovf | dov;
            if (state == R0) r00 <= y;
            if (state == R1) r01 <= y;
            if (state == R2) r10 <= y;
            if (state == R3) begin
                P_POST00 <= r00;
                P_POST01 <= o01;
                P_POST10 <= o10;
                P_POST11 <= y;
                done     <= 1'b1;
            end
        end
    end
endmodule
